// File: rtl/ieee754_argmax_seq_pkg.sv
// Shared definitions for the sequential IEEE-754 argmax block:
// float width and argmax FSM state encoding.
package ieee754_argmax_seq_pkg;

  localparam int unsigned FP_WIDTH = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_FIRST   = 2'd1,
    S_COMPARE = 2'd2,
    S_DONE    = 2'd3
  } argmax_state_e;

endpackage

// File: rtl/ieee754_argmax_seq_if.sv
// Stream/result bundle for ieee754_argmax_seq: the master drives start and
// the element stream, the slave returns ready, status and the winning result.
interface ieee754_argmax_seq_if #(
  parameter int unsigned IDX_W = 4
);
  import ieee754_argmax_seq_pkg::*;

  logic                start;
  logic                in_valid;
  logic                in_ready;
  logic [FP_WIDTH-1:0] in_data;
  logic                busy;
  logic                done;
  logic [FP_WIDTH-1:0] max_value;
  logic [IDX_W-1:0]    max_index;

  modport master (
    output start, in_valid, in_data,
    input  in_ready, busy, done, max_value, max_index
  );

  modport slave (
    input  start, in_valid, in_data,
    output in_ready, busy, done, max_value, max_index
  );

endinterface

// File: rtl/ieee754_compare.sv
// Combinational IEEE-754 single-precision strict greater-than (A > B).
// NaN operands and +0 vs -0 compare as not-greater, matching IEEE ordering.
module ieee754_compare
  import ieee754_argmax_seq_pkg::*;
(
  input  logic [FP_WIDTH-1:0] i_a,
  input  logic [FP_WIDTH-1:0] i_b,
  output logic                o_gt_c
);

  logic w_a_nan;
  logic w_b_nan;
  logic w_both_zero;

  assign w_a_nan     = (&i_a[30:23]) & (|i_a[22:0]);
  assign w_b_nan     = (&i_b[30:23]) & (|i_b[22:0]);
  assign w_both_zero = (i_a[30:0] == 31'd0) && (i_b[30:0] == 31'd0);

  // Sign decides first; equal signs compare magnitude, reversed when negative.
  always_comb begin
    o_gt_c = 1'b0;
    if (w_a_nan || w_b_nan || w_both_zero) begin
      o_gt_c = 1'b0;
    end else if (i_a[31] != i_b[31]) begin
      o_gt_c = i_b[31];
    end else if (!i_a[31]) begin
      o_gt_c = (i_a[30:0] > i_b[30:0]);
    end else begin
      o_gt_c = (i_a[30:0] < i_b[30:0]);
    end
  end

endmodule

// File: rtl/ieee754_argmax_seq.sv
// Sequential argmax over N_ELEMS streamed IEEE-754 singles, time-sharing one
// comparator against the running maximum; reports value and 0-based index.
module ieee754_argmax_seq
  import ieee754_argmax_seq_pkg::*;
#(
  parameter int unsigned N_ELEMS = 10
) (
  input  logic                 clk,
  input  logic                 rst,
  ieee754_argmax_seq_if.slave  bus
);

  localparam int unsigned    IDX_W = (N_ELEMS > 1) ? $clog2(N_ELEMS) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_ELEMS - 1);

  argmax_state_e       r_state;
  logic                r_in_ready;
  logic                r_busy;
  logic                r_done;
  logic [FP_WIDTH-1:0] r_max_value;
  logic [IDX_W-1:0]    r_max_index;
  logic [IDX_W-1:0]    r_cnt;

  logic w_xfer;
  logic w_gt;

  assign w_xfer = bus.in_valid & r_in_ready;

  ieee754_compare u_cmp (
    .i_a    (bus.in_data),
    .i_b    (r_max_value),
    .o_gt_c (w_gt)
  );

  // Control FSM, element counter and result registers share one process.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_max_value <= '0;
      r_max_index <= '0;
      r_cnt       <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_state    <= S_FIRST;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_cnt      <= '0;
          end
        end
        S_FIRST: begin
          if (w_xfer) begin
            r_max_value <= bus.in_data;
            r_max_index <= '0;
            r_cnt       <= IDX_W'(1);
            if (N_ELEMS == 1) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b0;
            end else begin
              r_state <= S_COMPARE;
            end
          end
        end
        S_COMPARE: begin
          if (w_xfer) begin
            if (w_gt) begin
              r_max_value <= bus.in_data;
              r_max_index <= r_cnt;
            end
            // Stop counting on the last element so cnt never wraps in a run.
            if (r_cnt == LAST_IDX) begin
              r_state    <= S_DONE;
              r_done     <= 1'b1;
              r_busy     <= 1'b0;
              r_in_ready <= 1'b0;
            end else begin
              r_cnt <= r_cnt + IDX_W'(1);
            end
          end
        end
        S_DONE: begin
          if (bus.start) begin
            r_state    <= S_FIRST;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
            r_cnt      <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.busy      = r_busy;
  assign bus.done      = r_done;
  assign bus.max_value = r_max_value;
  assign bus.max_index = r_max_index;

endmodule
